reciprocal_nr_pipe: RTL and testbench

//  Parametrised Newton-Raphson reciprocal unit: q = 1/d for a signed DIV_W-bit integer d.

---
 rtl/reciprocal_nr_pipe_pkg.sv | 29 ++
 rtl/reciprocal_nr_pipe_if.sv | 32 +++
 rtl/reciprocal_nr_pipe_lead_one.sv | 26 ++
 rtl/reciprocal_nr_pipe.sv | 111 +++++++++++
 tb/tb_reciprocal_nr_pipe.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/reciprocal_nr_pipe_pkg.sv
// Shared definitions for the Newton-Raphson reciprocal unit.
// Holds the fixed sizing (divisor width, fraction bits, iteration count),
// the derived widths, the Q2.FRAC_W constants 1.0 and 2.0, and the FSM
// state enum used by the top level and exposed on its debug port.
// NUM_ITER must stay >= clog2(FRAC_W)+1 for the iteration to converge.
package recip_pkg;

  localparam int DIV_W    = 8;
  localparam int FRAC_W   = 30;
  localparam int NUM_ITER = 12;
  localparam int OUT_W    = FRAC_W + 2;     // S1.FRAC_W quotient
  localparam int MX_W     = DIV_W + OUT_W;  // m*x product
  localparam int PROD_W   = 2 * OUT_W;      // x*(2-m*x) product
  localparam int Z_W      = $clog2(DIV_W);
  localparam int CNT_W    = $clog2(NUM_ITER + 1);

  localparam logic [OUT_W-1:0] ONE_Q   = OUT_W'(1) << FRAC_W;
  localparam logic [OUT_W-1:0] TWO_Q   = OUT_W'(2) << FRAC_W;
  localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    NORM = 3'd1,
    ITER = 3'd2,
    SIGN = 3'd3,
    OUT  = 3'd4
  } state_t;

endpackage

// File: rtl/reciprocal_nr_pipe_if.sv
// Handshake bundle between a divisor producer and the reciprocal unit.
// Signal names are written from the unit's point of view (i_ = into the unit).
//   i_valid/o_ready    : divisor channel; a transfer happens on a rising edge
//                        where both are high. i_divisor is only meaningful then.
//   o_valid/i_ready    : quotient channel; a transfer happens on a rising edge
//                        where both are high. Once o_valid rises, o_valid,
//                        o_quotient and o_div_zero stay constant until that edge.
//   o_quotient         : signed S1.FRAC_W reciprocal
//   o_div_zero         : qualifies o_valid, divisor was zero
// Modport slave is the unit, master is the producer/consumer side.
interface reciprocal_nr_pipe_if;
  import recip_pkg::*;

  logic             i_valid;
  logic             o_ready;
  logic [DIV_W-1:0] i_divisor;
  logic             o_valid;
  logic             i_ready;
  logic [OUT_W-1:0] o_quotient;
  logic             o_div_zero;

  modport slave (
    input  i_valid, i_divisor, i_ready,
    output o_ready, o_valid, o_quotient, o_div_zero
  );

  modport master (
    output i_valid, i_divisor, i_ready,
    input  o_ready, o_valid, o_quotient, o_div_zero
  );

endinterface

// File: rtl/reciprocal_nr_pipe_lead_one.sv
// Priority encoder for the divisor magnitude.
//   i_m        : unsigned magnitude |d|
//   o_z        : index of the most significant set bit (0 when i_m is 0)
//   o_is_pow2  : exactly one bit set
//   o_is_zero  : no bit set
module recip_lead_one
  import recip_pkg::*;
(
  input  logic [DIV_W-1:0] i_m,
  output logic [Z_W-1:0]   o_z,
  output logic             o_is_pow2,
  output logic             o_is_zero
);

  always_comb begin
    o_z = '0;
    // Later (higher) indices overwrite earlier ones, leaving the leading one.
    for (int i = 0; i < DIV_W; i++) begin
      if (i_m[i]) o_z = Z_W'(i);
    end
  end

  assign o_is_zero = (i_m == '0);
  assign o_is_pow2 = !o_is_zero && ((i_m & (i_m - DIV_W'(1))) == '0);

endmodule

// File: rtl/reciprocal_nr_pipe.sv
// Newton-Raphson reciprocal q = 1/d for a signed DIV_W-bit divisor,
// producing a signed S1.FRAC_W quotient.
// Ports:
//   i_clk      : clock, rising edge
//   i_reset_n  : asynchronous active-low reset
//   bus_if     : divisor/quotient handshake bundle (slave side)
//   o_state    : current FSM state, for observation only
// Flow: IDLE accepts and latches d; NORM seeds x from the leading-one index
// (exact 2^-z for powers of two, which skip straight to SIGN); ITER refines
// x <= x*(2 - m*x) for NUM_ITER cycles; SIGN applies the sign and raises
// o_valid; OUT holds the result until the consumer takes it.
module reciprocal_nr_pipe
  import recip_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  reciprocal_nr_pipe_if.slave  bus_if,
  output state_t               o_state
);

  state_t             r_state, w_next;
  logic [DIV_W-1:0]   r_d;
  logic [DIV_W-1:0]   w_abs;
  logic [Z_W-1:0]     w_z;
  logic               w_pow2, w_zero, w_accept;
  logic [OUT_W-1:0]   r_x, w_norm_x, w_e, w_x_next;
  logic [MX_W-1:0]    w_mx;
  logic [PROD_W-1:0]  w_xe;
  logic [CNT_W-1:0]   r_count;
  logic [OUT_W-1:0]   r_quot;
  logic               r_ovalid, r_dz;

  // Unsigned magnitude; -2^(DIV_W-1) maps to 2^(DIV_W-1) without overflow.
  assign w_abs = r_d[DIV_W-1] ? (~r_d + DIV_W'(1)) : r_d;

  recip_lead_one u_lead_one (
    .i_m       (w_abs),
    .o_z       (w_z),
    .o_is_pow2 (w_pow2),
    .o_is_zero (w_zero)
  );

  // m*x stays below 2.0, so its low OUT_W bits are the Q2.FRAC_W value.
  assign w_mx     = {{OUT_W{1'b0}}, w_abs} * {{DIV_W{1'b0}}, r_x};
  assign w_e      = TWO_Q - OUT_W'(w_mx);
  assign w_xe     = {{OUT_W{1'b0}}, r_x} * {{OUT_W{1'b0}}, w_e};
  assign w_x_next = OUT_W'(w_xe >> FRAC_W);  // truncating rescale

  // Seed: 2^-(z+1) keeps m*x0 in [0.5,1); powers of two get 2^-z exactly.
  assign w_norm_x = w_pow2 ? (ONE_Q >> w_z) : ((ONE_Q >> w_z) >> 1);

  assign w_accept          = bus_if.i_valid && (r_state == IDLE);
  assign bus_if.o_ready    = (r_state == IDLE);
  assign bus_if.o_valid    = r_ovalid;
  assign bus_if.o_quotient = r_quot;
  assign bus_if.o_div_zero = r_dz;
  assign o_state           = r_state;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = NORM;
      NORM: w_next = (w_pow2 || w_zero) ? SIGN : ITER;
      ITER: if (r_count == CNT_W'(NUM_ITER - 1)) w_next = SIGN;
      SIGN: w_next = OUT;
      OUT:  if (bus_if.i_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_d      <= '0;
      r_x      <= '0;
      r_count  <= '0;
      r_quot   <= '0;
      r_dz     <= 1'b0;
      r_ovalid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) r_d <= bus_if.i_divisor;
        NORM: begin
          r_x     <= w_norm_x;
          r_count <= '0;
        end
        ITER: begin
          r_x     <= w_x_next;
          r_count <= r_count + CNT_W'(1);
        end
        SIGN: begin
          r_ovalid <= 1'b1;
          if (w_zero) begin
            r_quot <= MAX_POS;
            r_dz   <= 1'b1;
          end else begin
            r_quot <= r_d[DIV_W-1] ? (~r_x + OUT_W'(1)) : r_x;
            r_dz   <= 1'b0;
          end
        end
        OUT: if (bus_if.i_ready) r_ovalid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reciprocal_nr_pipe.sv
// Self-checking bench for reciprocal_nr_pipe: directed cases, hold/stability,
// mid-operation reset and a randomized sweep of every divisor checked by a
// scoreboard against the exact rational 2^FRAC_W/d.
module tb_reciprocal_nr_pipe;
  import recip_pkg::*;

  // ---------------- clock / reset ----------------
  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;

  always #5 clk = ~clk;

  reciprocal_nr_pipe_if u_if ();

  reciprocal_nr_pipe u_dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus_if    (u_if),
    .o_state   (dbg_state)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int               n_checks = 0;
  int               n_errors = 0;
  logic [DIV_W-1:0] exp_q[$];

  task automatic chk(input string tag, input longint got, input longint exp, input longint tol);
    longint diff;
    diff = got - exp;
    if (diff < 0) diff = -diff;
    n_checks++;
    if (diff > tol) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) tol %0d", tag, got, got, exp, exp, tol);
    end
  endtask

  // Reference: q*d must be within 2|d| of 2^FRAC_W (i.e. |q - 2^FRAC_W/d| <= 2 LSB),
  // exactly 2^FRAC_W when |d| is a power of two; d=0 gives max positive + flag.
  task automatic check_result(input logic [DIV_W-1:0] d, input logic [OUT_W-1:0] q, input logic dz);
    longint dv, qv, mag, tol;
    string  tag;
    dv  = longint'(signed'(d));
    qv  = longint'(signed'(q));
    mag = (dv < 0) ? -dv : dv;
    tag = $sformatf("d=%0d", dv);
    if (dv == 0) begin
      chk({tag, " q"},  longint'(q), 64'h7FFF_FFFF, 0);
      chk({tag, " dz"}, longint'(dz), 1, 0);
    end else begin
      tol = ((mag & (mag - 1)) == 0) ? 0 : 2 * mag;
      chk({tag, " dz"},   longint'(dz), 0, 0);
      chk({tag, " q*d"},  qv * dv, longint'(1) << FRAC_W, tol);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One full transaction; all driving and sampling happens on falling edges.
  task automatic run_op(input logic [DIV_W-1:0] d, input int hold,
                        output logic [OUT_W-1:0] q, output logic dz, output int lat);
    int n;
    u_if.i_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!u_if.o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", longint'(u_if.o_ready), 1, 0);
    u_if.i_valid   = 1'b1;
    u_if.i_divisor = d;
    @(negedge clk);                 // accepting edge has passed
    u_if.i_valid   = 1'b0;
    u_if.i_divisor = ~d;            // must not affect the result
    lat = 0;
    while (!u_if.o_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    q  = u_if.o_quotient;
    dz = u_if.o_div_zero;
    for (int c = 0; c < hold; c++) begin
      u_if.i_divisor = DIV_W'($urandom);
      @(negedge clk);
      chk("hold_valid", longint'(u_if.o_valid), 1, 0);
      chk("hold_q",     longint'(u_if.o_quotient), longint'(q), 0);
      chk("hold_dz",    longint'(u_if.o_div_zero), longint'(dz), 0);
      chk("hold_ready", longint'(u_if.o_ready), 0, 0);
    end
    u_if.i_ready = 1'b1;
    @(negedge clk);
    u_if.i_ready = 1'b0;
    chk("post_valid", longint'(u_if.o_valid), 0, 0);
    chk("post_q",     longint'(u_if.o_quotient), longint'(q), 0);
    chk("post_ready", longint'(u_if.o_ready), 1, 0);
  endtask

  // ---------------- main sequence ----------------
  logic [OUT_W-1:0] q;
  logic             dz;
  int               lat;
  int               perm[256];
  int               got_cnt;

  initial begin
    u_if.i_valid   = 1'b0;
    u_if.i_ready   = 1'b0;
    u_if.i_divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", longint'(u_if.o_valid), 0, 0);
    chk("rst_q",     longint'(u_if.o_quotient), 0, 0);
    chk("rst_dz",    longint'(u_if.o_div_zero), 0, 0);
    chk("rst_ready", longint'(u_if.o_ready), 1, 0);
    rst_n = 1'b1;

    run_op(8'd8, 0, q, dz, lat);
    chk("d8_q", longint'(q), 64'h0800_0000, 0);
    chk("d8_dz", longint'(dz), 0, 0);
    chk("d8_lat", lat, 2, 0);

    run_op(8'd3, 10, q, dz, lat);
    chk("d3_lat", lat, NUM_ITER + 2, 0);
    chk("d3_q", longint'(q), 64'h1555_5555, 2);
    check_result(8'd3, q, dz);

    run_op(8'h80, 0, q, dz, lat);
    chk("dm128_q", longint'(q), 64'hFF80_0000, 0);
    chk("dm128_lat", lat, 2, 0);
    run_op(8'hFF, 0, q, dz, lat);
    chk("dm1_q", longint'(q), 64'hC000_0000, 0);
    run_op(8'd1, 0, q, dz, lat);
    chk("d1_q", longint'(q), 64'h4000_0000, 0);

    run_op(8'd0, 3, q, dz, lat);
    chk("d0_q", longint'(q), 64'h7FFF_FFFF, 0);
    chk("d0_dz", longint'(dz), 1, 0);
    chk("d0_lat", lat, 2, 0);
    run_op(8'd5, 0, q, dz, lat);
    chk("d5_dz", longint'(dz), 0, 0);
    check_result(8'd5, q, dz);

    // Reset in the middle of an iteration, right after a zero-divide result.
    run_op(8'd0, 0, q, dz, lat);
    u_if.i_valid   = 1'b1;
    u_if.i_divisor = 8'd3;
    @(negedge clk);
    u_if.i_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_state_iter", longint'(dbg_state == ITER), 1, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", longint'(u_if.o_valid), 0, 0);
    chk("mid_rst_q",     longint'(u_if.o_quotient), 0, 0);
    chk("mid_rst_dz",    longint'(u_if.o_div_zero), 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("mid_no_valid", longint'(u_if.o_valid), 0, 0);
    run_op(8'd7, 0, q, dz, lat);
    chk("d7_lat", lat, NUM_ITER + 2, 0);
    check_result(8'd7, q, dz);

    // Random sweep over every divisor in shuffled order.
    for (int i = 0; i < 256; i++) perm[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j, t;
      j = $urandom_range(i, 0);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    got_cnt = 0;
    @(negedge clk);
    fork
      begin : driver
        for (int k = 0; k < 256; k++) begin
          int n;
          repeat ($urandom_range(3, 0)) @(negedge clk);
          u_if.i_valid   = 1'b1;
          u_if.i_divisor = DIV_W'(perm[k]);
          n = 0;
          while (!u_if.o_ready && n < 200) begin
            @(negedge clk);
            n++;
          end
          if (!u_if.o_ready) begin
            chk("sweep_accept_timeout", n, 0, 0);
            break;
          end
          exp_q.push_back(DIV_W'(perm[k]));
          @(negedge clk);
          u_if.i_valid = 1'b0;
        end
        u_if.i_valid = 1'b0;
      end
      begin : sink
        int budget;
        logic [DIV_W-1:0] d;
        budget = 0;
        while (got_cnt < 256 && budget < 20000) begin
          @(negedge clk);
          budget++;
          u_if.i_ready = ($urandom_range(3, 0) != 0);
          if (u_if.o_valid && u_if.i_ready) begin
            if (exp_q.size() == 0) begin
              chk("sweep_unexpected", 1, 0, 0);
            end else begin
              d = exp_q.pop_front();
              check_result(d, u_if.o_quotient, u_if.o_div_zero);
            end
            got_cnt++;
          end
        end
        u_if.i_ready = 1'b0;
      end
    join
    chk("sweep_count", got_cnt, 256, 0);
    chk("sweep_leftover", exp_q.size(), 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
